// File: rtl/matmul_seq_ctrl.sv
// rtl/matmul_seq_ctrl.sv - sequencer for the 3x3 MAC array
//
// Holds two 3x3 operand stores (W, X) written by the host, runs one
// clear / three-step outer-product / capture sequence per start, and
// keeps the nine accumulator results in a readable register file.
//
// Ports:
//   clk, clear             clock, synchronous active-high reset
//   wr_en/wr_sel/wr_row/wr_col/wr_data
//                          operand write (sel 0 = W, 1 = X), IDLE only
//   start                  request one multiplication (IDLE only)
//   busy, done             sequence in progress / one-cycle result-valid pulse
//   data_w1..3, data_x1..3 row / column operands to the array
//   mac_load, mac_clear    array accumulate enable / accumulator clear
//   o11..o33               array accumulator outputs
//   rd_row/rd_col, rd_data result read address / combinational result

module matmul_seq_ctrl #(
  parameter int DW = 4,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [1:0]    wr_row,
  input  logic [1:0]    wr_col,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] data_w1,
  output logic [DW-1:0] data_w2,
  output logic [DW-1:0] data_w3,
  output logic [DW-1:0] data_x1,
  output logic [DW-1:0] data_x2,
  output logic [DW-1:0] data_x3,
  output logic          mac_load,
  output logic          mac_clear,
  input  logic [AW-1:0] o11,
  input  logic [AW-1:0] o12,
  input  logic [AW-1:0] o13,
  input  logic [AW-1:0] o21,
  input  logic [AW-1:0] o22,
  input  logic [AW-1:0] o23,
  input  logic [AW-1:0] o31,
  input  logic [AW-1:0] o32,
  input  logic [AW-1:0] o33,
  input  logic [1:0]    rd_row,
  input  logic [1:0]    rd_col,
  output logic [AW-1:0] rd_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ACC0,
    S_ACC1,
    S_ACC2,
    S_CAPT
  } state_t;

  state_t state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   load_q, load_d;
  logic   clr_q, clr_d;

  // Element [i] of these drives data_w(i+1) / data_x(i+1).
  logic [2:0][DW-1:0] dw_q, dw_d;
  logic [2:0][DW-1:0] dx_q, dx_d;

  // Matrices are stored row-major: element [r][c] lives at index 3*r+c.
  logic [8:0][DW-1:0] w_q, w_d;
  logic [8:0][DW-1:0] x_q, x_d;
  logic [8:0][AW-1:0] res_q, res_d;

  logic [3:0] widx;
  logic [3:0] ridx;

  assign widx = {2'b00, wr_row} * 4'd3 + {2'b00, wr_col};
  assign ridx = {2'b00, rd_row} * 4'd3 + {2'b00, rd_col};

  // Next state and registered outputs. Outputs are derived from the next
  // state so that they line up with the state register on the same edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CLR;
      S_CLR:   state_d = S_ACC0;
      S_ACC0:  state_d = S_ACC1;
      S_ACC1:  state_d = S_ACC2;
      S_ACC2:  state_d = S_CAPT;
      S_CAPT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_CAPT);
    clr_d  = (state_d == S_CLR);
    load_d = 1'b0;
    dw_d   = '0;
    dx_d   = '0;

    // Step k presents column k of W and row k of X.
    unique case (state_d)
      S_ACC0: begin
        load_d = 1'b1;
        dw_d   = {w_q[6], w_q[3], w_q[0]};
        dx_d   = {x_q[2], x_q[1], x_q[0]};
      end
      S_ACC1: begin
        load_d = 1'b1;
        dw_d   = {w_q[7], w_q[4], w_q[1]};
        dx_d   = {x_q[5], x_q[4], x_q[3]};
      end
      S_ACC2: begin
        load_d = 1'b1;
        dw_d   = {w_q[8], w_q[5], w_q[2]};
        dx_d   = {x_q[8], x_q[7], x_q[6]};
      end
      default: begin
        load_d = 1'b0;
      end
    endcase
  end

  // Result capture on the closing edge of CAPT.
  always_comb begin
    res_d = res_q;
    if (state_q == S_CAPT) begin
      res_d = {o33, o32, o31, o23, o22, o21, o13, o12, o11};
    end
  end

  // Operand stores: writes only land while idle and out of reset, and a
  // row or column address of 3 is dropped.
  always_comb begin
    w_d = w_q;
    x_d = x_q;
    if (wr_en && !clear && (state_q == S_IDLE) &&
        (wr_row != 2'd3) && (wr_col != 2'd3)) begin
      if (wr_sel) begin
        x_d[widx] = wr_data;
      end else begin
        w_d[widx] = wr_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if ((rd_row != 2'd3) && (rd_col != 2'd3)) begin
      rd_data = res_q[ridx];
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      clr_q   <= 1'b0;
      dw_q    <= '0;
      dx_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      load_q  <= load_d;
      clr_q   <= clr_d;
      dw_q    <= dw_d;
      dx_q    <= dx_d;
      res_q   <= res_d;
    end
  end

  // Operand stores deliberately survive reset so W can be reused.
  always_ff @(posedge clk) begin
    w_q <= w_d;
    x_q <= x_d;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mac_load  = load_q;
  // The array sees reset directly so it is cleared in the same cycle.
  assign mac_clear = clear | clr_q;
  assign data_w1   = dw_q[0];
  assign data_w2   = dw_q[1];
  assign data_w3   = dw_q[2];
  assign data_x1   = dx_q[0];
  assign data_x2   = dx_q[1];
  assign data_x3   = dx_q[2];

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb/tb_matmul_seq_ctrl.sv - self-checking bench for matmul_seq_ctrl
module tb_matmul_seq_ctrl;
  localparam int DW = 4;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          clear, wr_en, wr_sel, start;
  logic [1:0]    wr_row, wr_col, rd_row, rd_col;
  logic [DW-1:0] wr_data;
  logic          busy, done, mac_load, mac_clear;
  logic [DW-1:0] data_w1, data_w2, data_w3, data_x1, data_x2, data_x3;
  logic [AW-1:0] o11, o12, o13, o21, o22, o23, o31, o32, o33;
  logic [AW-1:0] rd_data;

  matmul_seq_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .clear(clear), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .start(start),
    .busy(busy), .done(done),
    .data_w1(data_w1), .data_w2(data_w2), .data_w3(data_w3),
    .data_x1(data_x1), .data_x2(data_x2), .data_x3(data_x3),
    .mac_load(mac_load), .mac_clear(mac_clear),
    .o11(o11), .o12(o12), .o13(o13), .o21(o21), .o22(o22), .o23(o23),
    .o31(o31), .o32(o32), .o33(o33),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural 3x3 MAC array driven by the DUT.
  logic [DW-1:0] bw[3], bx[3];
  logic [AW-1:0] acc[3][3];
  assign bw[0] = data_w1; assign bw[1] = data_w2; assign bw[2] = data_w3;
  assign bx[0] = data_x1; assign bx[1] = data_x2; assign bx[2] = data_x3;
  initial for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) acc[i][j] = '0;
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (mac_clear) acc[i][j] <= '0;
        else if (mac_load) acc[i][j] <= acc[i][j] + AW'(bw[i]) * AW'(bx[j]);
  end
  assign o11 = acc[0][0]; assign o12 = acc[0][1]; assign o13 = acc[0][2];
  assign o21 = acc[1][0]; assign o22 = acc[1][1]; assign o23 = acc[1][2];
  assign o31 = acc[2][0]; assign o32 = acc[2][1]; assign o33 = acc[2][2];

  // Reference model: matrices as plain ints, ph = cycles since start (0 = idle).
  int mw[3][3], mx[3][3], mres[3][3];
  int ph = 0;
  bit done_exp = 1'b0;
  always @(posedge clk) begin
    if (clear) begin
      ph = 0;
      done_exp = 1'b0;
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) mres[i][j] = 0;
    end else begin
      done_exp = (ph == 5);
      if (ph == 5) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            mres[i][j] = 0;
            for (int k = 0; k < 3; k++) mres[i][j] += mw[i][k] * mx[k][j];
          end
        ph = 0;
      end else if (ph == 0) begin
        if (wr_en && wr_row != 2'd3 && wr_col != 2'd3) begin
          if (wr_sel) mx[wr_row][wr_col] = int'(wr_data);
          else        mw[wr_row][wr_col] = int'(wr_data);
        end
        if (start) ph = 1;
      end else begin
        ph = ph + 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : cmp
    int ew[3], ex[3], er;
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        ew[i] = (ph >= 2 && ph <= 4) ? mw[i][ph-2] : 0;
        ex[i] = (ph >= 2 && ph <= 4) ? mx[ph-2][i] : 0;
      end
      er = (rd_row != 2'd3 && rd_col != 2'd3) ? mres[rd_row][rd_col] : 0;
      check("busy", int'(busy), int'(ph != 0));
      check("done", int'(done), int'(done_exp));
      check("mac_load", int'(mac_load), int'(ph >= 2 && ph <= 4));
      check("mac_clear", int'(mac_clear), int'(clear || ph == 1));
      for (int i = 0; i < 3; i++) begin
        check($sformatf("data_w%0d", i + 1), int'(bw[i]), ew[i]);
        check($sformatf("data_x%0d", i + 1), int'(bx[i]), ex[i]);
      end
      check("rd_data", int'(rd_data), er);
    end
  end

  int tw[3][3], tx[3][3];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int s, input int r, input int c, input int d);
    wr_en = 1'b1; wr_sel = s[0]; wr_row = 2'(r); wr_col = 2'(c); wr_data = 4'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic write_all();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        wr(0, r, c, tw[r][c]);
        wr(1, r, c, tx[r][c]);
      end
  endtask

  task automatic run(output int lat, output int loads);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    loads = int'(mac_load);
    while (!done && lat < 20) begin
      tick();
      lat++;
      loads += int'(mac_load);
    end
    check("run_reaches_done", int'(done), 1);
  endtask

  task automatic rd_chk(input int r, input int c, input int exp);
    rd_row = 2'(r); rd_col = 2'(c);
    #1;
    check($sformatf("rd[%0d][%0d]", r, c), int'(rd_data), exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int lat, loads, dones, first, second;
    clear = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0;
    wr_data = '0; start = 1'b0; rd_row = 2'd0; rd_col = 2'd0;
    tick();
    chk_en = 1'b1;
    // Reset state literals.
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_mac_load", int'(mac_load), 0);
    check("rst_mac_clear", int'(mac_clear), 1);
    check("rst_data_w1", int'(data_w1), 0);
    rd_chk(1, 1, 0);
    tick();
    clear = 1'b0;
    tick();

    // Identity.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        tw[r][c] = (r == c) ? 1 : 0;
        tx[r][c] = 3 * r + c + 1;
      end
    write_all();
    run(lat, loads);
    check("ident_latency", lat, 6);
    check("ident_load_cycles", loads, 3);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        rd_chk(r, c, 3 * r + c + 1);
        check("model_ident", mres[r][c], 3 * r + c + 1);
      end
    rd_chk(3, 0, 0);
    rd_chk(2, 3, 0);
    tick();

    // Maximum operands.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        tw[r][c] = 15; tx[r][c] = 15;
      end
    write_all();
    run(lat, loads);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) rd_chk(r, c, 675);
    tick();

    // Non-trivial: X = W transposed.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        tw[r][c] = 3 * r + c + 1;
        tx[c][r] = 3 * r + c + 1;
      end
    write_all();
    run(lat, loads);
    rd_chk(0, 0, 14); rd_chk(0, 1, 32); rd_chk(0, 2, 50);
    rd_chk(2, 0, 50); rd_chk(2, 1, 122); rd_chk(2, 2, 194);
    check("model_nontriv", mres[2][1], 122);
    tick();

    // Busy rejection: write in cycle 2, second start in cycle 3.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    wr(0, 0, 0, 9);
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      dones += int'(done);
    end
    check("busy_reject_dones", dones, 1);
    rd_chk(0, 0, 14); rd_chk(0, 1, 32); rd_chk(0, 2, 50);
    tick();
    run(lat, loads);
    check("rerun_latency", lat, 6);
    rd_chk(0, 0, 14); rd_chk(1, 1, 77);
    tick();

    // Reset during ACC1.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("acc1_load", int'(mac_load), 1);
    clear = 1'b1;
    tick();
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_mac_clear", int'(mac_clear), 1);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) rd_chk(r, c, 0);
    clear = 1'b0;
    dones = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      dones += int'(done);
    end
    check("midrst_no_done", dones, 0);

    // Back-to-back with start held for 13 cycles.
    rd_row = 2'd2; rd_col = 2'd1;
    start = 1'b1;
    dones = 0; first = -1; second = -1;
    for (int n = 1; n <= 13; n++) begin
      tick();
      if (done) begin
        dones++;
        if (first < 0) first = n; else second = n;
        check("b2b_result", int'(rd_data), 122);
      end
    end
    start = 1'b0;
    check("b2b_dones", dones, 2);
    check("b2b_spacing", second - first, 6);
    for (int n = 0; n < 10; n++) tick();

    // Randomized traffic including writes, starts, bad addresses and resets.
    for (int n = 0; n < 600; n++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_sel  = 1'($urandom_range(0, 1));
      wr_row  = 2'($urandom_range(0, 3));
      wr_col  = 2'($urandom_range(0, 3));
      wr_data = 4'($urandom_range(0, 15));
      start   = ($urandom_range(0, 3) == 0);
      clear   = ($urandom_range(0, 40) == 0);
      rd_row  = 2'($urandom_range(0, 3));
      rd_col  = 2'($urandom_range(0, 3));
      tick();
    end
    wr_en = 1'b0; start = 1'b0; clear = 1'b0;
    for (int n = 0; n < 10; n++) tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_seq_ctrl.md
# matmul_seq_ctrl

Sequencer for the 3x3 MAC array (`matmul`). It holds two 3x3 operand matrices W and X of 4-bit unsigned values, written by a host. On `start` it clears the array, streams three outer-product steps into it, and captures the nine 10-bit accumulator outputs into a result register file. It sits between the host register interface and the array; the array's `load` and `clear` inputs are driven only by this block.

## Interface
Parameters:
- `DW`, 4: operand width. Fixed by the array.
- `AW`, 10: accumulator and result width. Fixed by the array.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `clear`  in  1  synchronous, active-high reset for this block.
- `wr_en`  in  1  operand write strobe.
- `wr_sel`  in  1  0 = W store, 1 = X store.
- `wr_row`, `wr_col`  in  2 each  element address, 0..2.
- `wr_data`  in  DW  element value.
- `start`  in  1  request one multiplication, sampled in IDLE only.
- `busy`  out  1  high while a multiplication is in progress.
- `done`  out  1  one-cycle pulse; results are valid.
- `data_w1`, `data_w2`, `data_w3`  out  DW  row operands to the array.
- `data_x1`, `data_x2`, `data_x3`  out  DW  column operands to the array.
- `mac_load`  out  1  array accumulate enable.
- `mac_clear`  out  1  array accumulator clear.
- `o11` .. `o33`  in  AW each  array accumulator outputs.
- `rd_row`, `rd_col`  in  2 each  result read address.
- `rd_data`  out  AW  result element C[rd_row][rd_col], combinational.

## Operation
- Array contract:
  - Each cell holds acc_ij. It updates on the rising `clk` edge.
  - `mac_clear`=1 sets acc to 0. This has priority over load.
  - Otherwise, `mac_load`=1 sets acc to acc + w_i*x_j.
  - `o_ij` is the registered acc.
- Computation: C[i][j] = sum over k=0..2 of W[i][k]*X[k][j].
  - Maximum value is 3*15*15 = 675. This fits in AW=10 bits, so no overflow is possible.
- FSM states: IDLE, CLR, ACC0, ACC1, ACC2, CAPT.
  - IDLE to CLR: `start`=1.
  - CLR to ACC0 to ACC1 to ACC2 to CAPT: unconditional.
  - CAPT to IDLE: unconditional.
- Outputs by state:
  - CLR: `mac_clear`=1, `mac_load`=0.
  - ACCk: `mac_load`=1. `data_w(i+1)` = W[i][k]. `data_x(j+1)` = X[k][j].
  - All other states: all `data_*` = 0 and `mac_load` = 0.
  - CAPT: on the closing edge, all nine `o_ij` are latched into result registers C[i][j]. The same edge sets `done`<=1.
- `mac_clear` = `clear` OR (state==CLR). The array is therefore cleared whenever the block is reset.
- `busy` = (state != IDLE).
- Operand writes:
  - Accepted only in IDLE. Writes while `busy` are dropped silently.
  - `wr_row` or `wr_col` equal to 3 is ignored.
  - Operand stores are not reset. They hold their values across runs, so the same W can be reused with a new X.
- Result reads:
  - `rd_row` or `rd_col` equal to 3 returns 0.
  - Results hold until the next CAPT.
- `start` while `busy` is ignored. It is not queued.

## Timing
- Reset values:
  - state = IDLE.
  - `busy`=0, `done`=0, `mac_load`=0, `mac_clear`=1 while `clear` is high.
  - All `data_*`=0.
  - Result registers = 0, so `rd_data`=0.
- Latency, counting from the edge that samples `start` in IDLE (edge 0):
  - Cycle 1 is CLR.
  - Cycles 2–4 are ACC0–ACC2.
  - Cycle 5 is CAPT.
  - Cycle 6: `done`=1 and `busy`=0.
  - Start to `done` is 6 cycles. `busy` is high for exactly 5 cycles.
- Back-to-back: a `start` sampled in the `done` cycle is accepted. Throughput is one result set per 6 cycles.
- A write in the same cycle that `start` is accepted (IDLE) takes effect before ACC0 and is used by this run.
- Reset mid-operation:
  - `clear` high in any state returns to IDLE on the next edge.
  - `done` is not pulsed.
  - Result registers are zeroed.
  - The array is cleared.
- `done` is never high while `busy` is high.

## Test plan
- Identity: W = I, X[r][c] = 3r+c+1. Write all, then `start`. Required: `done` exactly 6 cycles after start. C reads back 1..9 row-major. `mac_load` was high for exactly 3 cycles.
- Maximum: all W and X = 15. Required: every C = 675, with no truncation.
- Non-trivial: W rows (1,2,3),(4,5,6),(7,8,9); X = transpose of W. Required: C row 0 = (14,32,50), C row 2 = (50,122,194).
- Busy rejection:
  - Pulse `start` and write W[0][0]=9 in cycle 2; result must be unchanged.
  - Pulse `start` again in cycle 3; no second `done` may occur.
  - After `done`, rerun; result must still reflect the old W[0][0].
- Reset mid-run: assert `clear` during ACC1. Required: next cycle IDLE, `busy`=0, `done` never asserted, `rd_data`=0 for all addresses, `mac_clear`=1 during reset.
- Back-to-back: hold `start` high for 13 cycles with a fixed W and X. Required: exactly two `done` pulses, 6 cycles apart, with identical results.
